// File: rtl/pal_sdm_dac.sv
// pal_sdm_dac: second-order sigma-delta DAC turning 8-bit PAL samples into a 1-bit pulse stream; `SDM_DITHER_EN adds LFSR dither
module pal_sdm_dac #(
   parameter int IW = 8,
   parameter int AW = 12
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          enable,
   input  logic          sample_stb,
   input  logic [IW-1:0] sample_in,
   output logic [IW-1:0] sample_held,
   output logic          dac_out,
   output logic          sat
);
   localparam int SW = AW + 2;
   localparam logic signed [SW-1:0] MAXV = SW'((1 << (AW-1)) - 1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;
   localparam logic signed [SW-1:0] FB   = SW'(1 << IW);
   logic signed [AW-1:0] acc1, acc2;
   logic signed [SW-1:0] x, fb, d, s1, s2, c1, c2;
   logic                 o1, o2;
`ifdef SDM_DITHER_EN
   logic [15:0] lfsr;
   // dither source: x^16+x^14+x^13+x^11+1 LFSR, frozen while idle so restarts are repeatable
   always_ff @(posedge pclk)
      if (rst) lfsr <= 16'hACE1;
      else if (enable) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign d = lfsr[0] ? SW'(1) : '1;
`else
   assign d = '0;
`endif
   // two integrators with clamping; output is the sign of the clamped second stage
   always_comb begin
      x  = $signed(SW'(sample_held));
      fb = dac_out ? FB : '0;
      s1 = {{2{acc1[AW-1]}}, acc1} + x - fb + d;
      c1 = s1 > MAXV ? MAXV : s1 < MINV ? MINV : s1;
      s2 = {{2{acc2[AW-1]}}, acc2} + c1 - fb;
      c2 = s2 > MAXV ? MAXV : s2 < MINV ? MINV : s2;
      o1 = c1 != s1;
      o2 = c2 != s2;
   end
   // hold register keeps capturing strobes even while the modulator is idle
   always_ff @(posedge pclk)
      if (rst) sample_held <= '0;
      else if (sample_stb) sample_held <= sample_in;
   // modulator state: zeroed while idle so a restart never replays stale integrator contents
   always_ff @(posedge pclk)
      if (rst || !enable) begin
         acc1    <= '0;
         acc2    <= '0;
         dac_out <= 1'b0;
         sat     <= 1'b0;
      end else begin
         acc1    <= c1[AW-1:0];
         acc2    <= c2[AW-1:0];
         dac_out <= (c2 != '0) && !c2[SW-1];
         sat     <= sat | o1 | o2;
      end
endmodule
